cond_eval: RTL and testbench
============================

# cond_eval

Condition evaluation stage directly downstream of the 5-bit ALU status `flags` register. It accepts a condition-code request for Bcond, Jcond or Scond and samples the registered flags. It returns a registered taken/not-taken decision plus a zero-extended Scond value through a 2-entry valid/ready skid buffer. An optional bypass path forwards flags that are being written in the same cycle.

## Interface
- `P_FLAG_WIDTH`, 5, flag vector width; only 5 is legal. Bit order is {N, Z, F, L, C}, with bit0 = C.
- `P_DATA_WIDTH`, 16, width of the Scond result.
- `P_TAG_WIDTH`, 4, width of the passthrough tag (destination register index).
- `I_CLK` input 1: clock, rising edge.
- `I_RESET` input 1: asynchronous, active-high reset.
- `I_FLAGS` input P_FLAG_WIDTH: current flags, taken from the flags register output.
- `I_FLAGS_NEXT` input P_FLAG_WIDTH: flags being written this cycle, taken from the ALU.
- `I_FLAGS_WE` input 1: flags register enable for this cycle.
- `I_VALID` input 1: a request is present.
- `I_COND` input 4: CR16 condition code.
- `I_TAG` input P_TAG_WIDTH: request tag.
- `O_READY` output 1: the stage can accept a request.
- `O_VALID` output 1: a result is present.
- `I_OUT_READY` input 1: the consumer accepts the result.
- `O_TAKEN` output 1: the condition is true.
- `O_SET` output P_DATA_WIDTH: {(P_DATA_WIDTH-1)'b0, O_TAKEN}.
- `O_TAG` output P_TAG_WIDTH: the tag of the presented result.

## Operation
- Flags used for evaluation (Feff):
  - With the bypass compiled in, Feff = I_FLAGS_WE ? I_FLAGS_NEXT : I_FLAGS.
  - Without the bypass, Feff = I_FLAGS.
- Condition table:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 HI: L
  - 0101 LS: !L
  - 0110 GT: N
  - 0111 LE: !N
  - 1000 FS: F
  - 1001 FC: !F
  - 1010 LO: !L & !Z
  - 1011 HS: L | Z
  - 1100 LT: !N & !Z
  - 1101 GE: N | Z
  - 1110 UC: 1
  - 1111 reserved: 0
- Accept condition: accept = I_VALID & O_READY & !stall.
  - With the bypass, stall = 0.
  - Without the bypass, stall = I_FLAGS_WE.
- Each accepted request produces an entry {taken, tag}.
- Buffer states are tracked by a 2-bit occupancy count:
  - EMPTY: O_VALID=0, O_READY=1.
  - ONE: the main entry is valid; O_VALID=1, O_READY=1.
  - TWO: the main and skid entries are both valid; O_VALID=1, O_READY=0.
- Transitions (pop = O_VALID & I_OUT_READY):
  - EMPTY + accept → ONE.
  - ONE + accept & !pop → TWO; the new entry goes to the skid slot.
  - ONE + accept & pop → ONE; the new entry replaces the main slot.
  - ONE + !accept & pop → EMPTY.
  - TWO + pop → ONE; the skid entry moves to the main slot.
  - TWO ignores I_VALID because O_READY=0.
- Outputs always show the main entry, in strict FIFO order.
- O_READY is a registered output and never depends combinationally on I_OUT_READY.
- Without the bypass, O_READY is still driven purely from state. A request held off by `stall` must keep I_VALID, I_COND and I_TAG stable until it is accepted.
- Reset mid-operation discards all entries immediately. In-flight requests are lost, and the producer must reissue them.

## Timing
- Reset values: O_VALID=0, O_TAKEN=0, O_SET=0, O_TAG=0, O_READY=1, state EMPTY.
- Latency: a request accepted at edge k appears at O_VALID/O_TAKEN after edge k, with one cycle of latency.
- Throughput: one result per cycle while I_OUT_READY is held high.
- Flag timing:
  - With the bypass, a request in the same cycle as I_FLAGS_WE=1 evaluates against I_FLAGS_NEXT.
  - Without the bypass, that request is accepted in the first cycle with I_FLAGS_WE=0 and evaluates against the then-registered flags.
- Simultaneous accept and pop in ONE: the result is valid again the next cycle, with no bubble.
- O_TAG and O_SET update on the same edge as O_TAKEN.

## Configuration
- Macro: `COND_EVAL_FLAG_BYPASS_EN`.
- Defined: the I_FLAGS_NEXT bypass is active, and there are never flag-hazard stalls.
- Undefined: I_FLAGS_NEXT is unused, and acceptance is blocked in every cycle with I_FLAGS_WE=1.

## Test plan
- Reset, then I_FLAGS=5'b01000 (Z=1). Issue EQ, NE, HS, LT, UC, 1111 back-to-back with I_OUT_READY=1. Required O_TAKEN sequence: 1,0,1,0,1,0, one per cycle starting one cycle after the first accept.
- Hold I_OUT_READY=0 and issue 3 requests with tags 1,2,3. Tags 1 and 2 are accepted; O_READY falls after the second accept and tag 3 is held. Raise I_OUT_READY: O_TAG sequence is 1, 2, 3, with no loss and no duplication.
- With the bypass: I_FLAGS=0, I_FLAGS_NEXT=5'b00001, I_FLAGS_WE=1, request CS. Required O_TAKEN=1 next cycle, O_SET=16'h0001.
- Without the bypass, same stimulus: no accept while I_FLAGS_WE=1. The next cycle has I_FLAGS_WE=0 and I_FLAGS=5'b00001; the request is accepted then, and O_TAKEN=1 one cycle later.
- Reach state TWO, then assert I_RESET asynchronously mid-cycle. Required immediately: O_VALID=0 and O_READY=1. Required after release: O_TAG=0, with no stale results.

Source files
------------

// File: rtl/cond_eval.sv
// Condition evaluation stage: evaluates a condition code against ALU flags and returns
// the result through a 2-entry skid buffer. Optional bypass: COND_EVAL_FLAG_BYPASS_EN.
`timescale 1ns/1ps

module cond_eval #(
  parameter int unsigned P_FLAG_WIDTH = 5,
  parameter int unsigned P_DATA_WIDTH = 16,
  parameter int unsigned P_TAG_WIDTH  = 4
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  input  logic [P_FLAG_WIDTH-1:0] I_FLAGS,
  input  logic [P_FLAG_WIDTH-1:0] I_FLAGS_NEXT,
  input  logic                    I_FLAGS_WE,
  input  logic                    I_VALID,
  input  logic [3:0]              I_COND,
  input  logic [P_TAG_WIDTH-1:0]  I_TAG,
  output logic                    O_READY,
  output logic                    O_VALID,
  input  logic                    I_OUT_READY,
  output logic                    O_TAKEN,
  output logic [P_DATA_WIDTH-1:0] O_SET,
  output logic [P_TAG_WIDTH-1:0]  O_TAG
);

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic                   taken;
    logic [P_TAG_WIDTH-1:0] tag;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   valid_q, valid_d;
  logic   ready_q, ready_d;

  logic [P_FLAG_WIDTH-1:0] feff_c;
  logic                    stall_c;
  logic                    taken_c;
  logic                    accept_c;
  logic                    pop_c;

  // Without the bypass, a request in a flag-write cycle waits for the registered flags.
`ifdef COND_EVAL_FLAG_BYPASS_EN
  assign feff_c  = I_FLAGS_WE ? I_FLAGS_NEXT : I_FLAGS;
  assign stall_c = 1'b0;
`else
  logic flags_next_unused;
  assign flags_next_unused = ^I_FLAGS_NEXT;
  assign feff_c  = I_FLAGS;
  assign stall_c = I_FLAGS_WE;
`endif

  // Condition code decode.
  always_comb begin
    taken_c = 1'b0;
    case (I_COND)
      4'h0: taken_c = feff_c[FLAG_Z];
      4'h1: taken_c = ~feff_c[FLAG_Z];
      4'h2: taken_c = feff_c[FLAG_C];
      4'h3: taken_c = ~feff_c[FLAG_C];
      4'h4: taken_c = feff_c[FLAG_L];
      4'h5: taken_c = ~feff_c[FLAG_L];
      4'h6: taken_c = feff_c[FLAG_N];
      4'h7: taken_c = ~feff_c[FLAG_N];
      4'h8: taken_c = feff_c[FLAG_F];
      4'h9: taken_c = ~feff_c[FLAG_F];
      4'hA: taken_c = ~feff_c[FLAG_L] & ~feff_c[FLAG_Z];
      4'hB: taken_c = feff_c[FLAG_L] | feff_c[FLAG_Z];
      4'hC: taken_c = ~feff_c[FLAG_N] & ~feff_c[FLAG_Z];
      4'hD: taken_c = feff_c[FLAG_N] | feff_c[FLAG_Z];
      4'hE: taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
  end

  assign accept_c = I_VALID & ready_q & ~stall_c;
  assign pop_c    = valid_q & I_OUT_READY;

  // Skid buffer occupancy and entry movement.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_ONE;
          main_d  = '{taken: taken_c, tag: I_TAG};
        end
      end
      ST_ONE: begin
        if (accept_c && !pop_c) begin
          state_d = ST_TWO;
          skid_d  = '{taken: taken_c, tag: I_TAG};
        end else if (accept_c && pop_c) begin
          main_d  = '{taken: taken_c, tag: I_TAG};
        end else if (pop_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop_c) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign O_READY = ready_q;
  assign O_VALID = valid_q;
  assign O_TAKEN = main_q.taken;
  assign O_TAG   = main_q.tag;
  assign O_SET   = {{(P_DATA_WIDTH-1){1'b0}}, main_q.taken};

endmodule

// File: tb/tb_cond_eval.sv
// Self-checking bench for cond_eval: directed steps plus randomized traffic against a
// queue-based reference model.
`timescale 1ns/1ps

module tb_cond_eval;

  typedef struct packed {
    logic       taken;
    logic [3:0] tag;
  } ent_t;

  logic        clk;
  logic        I_RESET;
  logic [4:0]  I_FLAGS;
  logic [4:0]  I_FLAGS_NEXT;
  logic        I_FLAGS_WE;
  logic        I_VALID;
  logic [3:0]  I_COND;
  logic [3:0]  I_TAG;
  logic        O_READY;
  logic        O_VALID;
  logic        I_OUT_READY;
  logic        O_TAKEN;
  logic [15:0] O_SET;
  logic [3:0]  O_TAG;

  int   checks;
  int   failures;
  ent_t q[$];
  logic last_accept;

  cond_eval #(.P_FLAG_WIDTH(5), .P_DATA_WIDTH(16), .P_TAG_WIDTH(4)) dut (
    .I_CLK(clk), .I_RESET(I_RESET), .I_FLAGS(I_FLAGS), .I_FLAGS_NEXT(I_FLAGS_NEXT),
    .I_FLAGS_WE(I_FLAGS_WE), .I_VALID(I_VALID), .I_COND(I_COND), .I_TAG(I_TAG),
    .O_READY(O_READY), .O_VALID(O_VALID), .I_OUT_READY(I_OUT_READY),
    .O_TAKEN(O_TAKEN), .O_SET(O_SET), .O_TAG(O_TAG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conditions come in pairs (true form, negated form) over a base predicate.
  function automatic logic ref_taken(input logic [3:0] c, input logic [4:0] f);
    logic n, z, fl, l, cy, base, inv;
    int   p;
    n = f[4]; z = f[3]; fl = f[2]; l = f[1]; cy = f[0];
    p = int'(c) >> 1;
    case (p)
      0: base = z;
      1: base = cy;
      2: base = l;
      3: base = n;
      4: base = fl;
      5: base = l | z;
      6: base = n | z;
      default: base = 1'b1;
    endcase
    inv = (p == 5 || p == 6) ? ~c[0] : c[0];
    return base ^ inv;
  endfunction

  task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 16'(O_VALID), 16'(q.size() > 0));
    chk("ready", 16'(O_READY), 16'(q.size() < 2));
    if (q.size() > 0) begin
      chk("taken", 16'(O_TAKEN), 16'(q[0].taken));
      chk("tag",   16'(O_TAG),   16'(q[0].tag));
      chk("set",   O_SET,        16'(q[0].taken));
    end
  endtask

  // One clock: predict from inputs presented before the edge, then check after it.
  task automatic step();
    logic [4:0] fe;
    logic       stall, acc, pop, tk;
    logic [3:0] tg;
`ifdef COND_EVAL_FLAG_BYPASS_EN
    fe    = I_FLAGS_WE ? I_FLAGS_NEXT : I_FLAGS;
    stall = 1'b0;
`else
    fe    = I_FLAGS;
    stall = I_FLAGS_WE;
`endif
    acc = I_VALID && (q.size() < 2) && !stall;
    pop = (q.size() > 0) && I_OUT_READY;
    tk  = ref_taken(I_COND, fe);
    tg  = I_TAG;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back('{taken: tk, tag: tg});
    last_accept = acc;
    check_outputs();
  endtask

  initial begin
    logic [3:0] conds [6];
    logic       exp_tk [6];
    logic [3:0] got [$];
    checks = 0; failures = 0; last_accept = 1'b0;
    conds  = '{4'h0, 4'h1, 4'hB, 4'hC, 4'hE, 4'hF};
    exp_tk = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset values
    I_RESET = 1'b1; I_FLAGS = '0; I_FLAGS_NEXT = '0; I_FLAGS_WE = 1'b0;
    I_VALID = 1'b0; I_COND = '0; I_TAG = '0; I_OUT_READY = 1'b0;
    #12;
    chk("rst_valid", 16'(O_VALID), 16'd0);
    chk("rst_ready", 16'(O_READY), 16'd1);
    chk("rst_taken", 16'(O_TAKEN), 16'd0);
    chk("rst_set",   O_SET,        16'd0);
    chk("rst_tag",   16'(O_TAG),   16'd0);
    @(negedge clk);
    I_RESET = 1'b0;

    // Back-to-back conditions with Z=1
    I_FLAGS = 5'b01000; I_OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      I_VALID = 1'b1; I_COND = conds[i]; I_TAG = 4'(i);
      step();
      chk("seq_valid", 16'(O_VALID), 16'd1);
      chk("seq_taken", 16'(O_TAKEN), 16'(exp_tk[i]));
    end
    I_VALID = 1'b0;
    step();

    // Backpressure: tags 1,2,3 with consumer stalled
    I_OUT_READY = 1'b0; I_COND = 4'hE;
    I_VALID = 1'b1; I_TAG = 4'd1; step();
    I_TAG = 4'd2; step();
    chk("bp_ready_low", 16'(O_READY), 16'd0);
    I_TAG = 4'd3; step();
    chk("bp_hold_tag", 16'(O_TAG), 16'd1);
    I_OUT_READY = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (q.size() == 0 && !I_VALID) break;
      if (O_VALID && I_OUT_READY) got.push_back(O_TAG);
      step();
      if (last_accept) I_VALID = 1'b0;
    end
    chk("bp_count", 16'(got.size()), 16'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < got.size()) ? 16'(got[i]) : 16'hFFFF, 16'(i + 1));

    // Flag hazard: write of C in the same cycle as a CS request
    I_FLAGS = 5'b00000; I_FLAGS_NEXT = 5'b00001; I_FLAGS_WE = 1'b1;
    I_VALID = 1'b1; I_COND = 4'h2; I_TAG = 4'd7;
    step();
`ifdef COND_EVAL_FLAG_BYPASS_EN
    chk("byp_taken", 16'(O_TAKEN), 16'd1);
    chk("byp_set",   O_SET,        16'h0001);
`else
    chk("stall_no_accept", 16'(O_VALID), 16'd0);
    I_FLAGS_WE = 1'b0; I_FLAGS = 5'b00001;
    step();
    chk("stall_taken", 16'(O_TAKEN), 16'd1);
    chk("stall_set",   O_SET,        16'h0001);
`endif
    I_VALID = 1'b0; I_FLAGS_WE = 1'b0;
    step();

    // Randomized traffic; an unaccepted request is held stable
    for (int n = 0; n < 400; n++) begin
      I_FLAGS      = 5'($urandom);
      I_FLAGS_NEXT = 5'($urandom);
      I_FLAGS_WE   = ($urandom_range(0, 3) == 0);
      I_OUT_READY  = ($urandom_range(0, 3) != 0);
      if (!(I_VALID && !last_accept)) begin
        I_VALID = ($urandom_range(0, 9) < 7);
        I_COND  = 4'($urandom);
        I_TAG   = 4'($urandom);
      end
      step();
    end

    // Fill to two entries, then reset asynchronously mid-cycle
    I_FLAGS_WE = 1'b0; I_OUT_READY = 1'b0; I_VALID = 1'b1; I_COND = 4'hE; I_TAG = 4'd9;
    for (int k = 0; k < 4; k++) begin
      if (q.size() == 2) break;
      step();
    end
    chk("two_ready", 16'(O_READY), 16'd0);
    #2;
    I_RESET = 1'b1;
    #1;
    chk("arst_valid", 16'(O_VALID), 16'd0);
    chk("arst_ready", 16'(O_READY), 16'd1);
    q.delete();
    I_VALID = 1'b0;
    #3;
    I_RESET = 1'b0;
    step();
    chk("post_rst_tag",   16'(O_TAG),   16'd0);
    chk("post_rst_valid", 16'(O_VALID), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
